proc_core: RTL and testbench

8-bit single-cycle processor with four general registers, a 16-byte internal data memory and seven-segment status outputs. It fetches one 8-bit instruction per executed cycle from an external combinational instruction ROM (`imem`: `Read_Address[7:0]` in, `instruction[7:0]` out) and drives board displays for the output value, the PC and the current opcode. It sits at the top of the board design, between the ROM and the display/LED pins.

---
 rtl/proc_core_pkg.sv | 17 +
 rtl/proc_core_seg7_hex.sv | 11 +
 rtl/proc_core.sv | 93 +++++++++
 tb/tb_proc_core.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_core_pkg.sv
// Shared definitions for proc_core: opcode encodings and the active-low
// seven-segment glyph table (bit6 = a ... bit0 = g).
package proc_core_pkg;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_JMP   = 2'b11;

  localparam logic [6:0] SEG_LUT [0:15] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/proc_core_seg7_hex.sv
// One hex digit to an active-low seven-segment pattern.
module seg7_hex
  import proc_core_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[hex];

endmodule

// File: rtl/proc_core.sv
// 8-bit single-cycle processor: 4 registers, 16-byte data memory, external
// instruction ROM, and hex displays for |OUT|, PC and the current opcode.
module proc_core
  import proc_core_pkg::*;
#(
  parameter int CLK_DIV = 1
)
(
  input  logic       CLK_osc,
  input  logic       RST,
  input  logic       HALT,
  input  logic [7:0] inst,
  output logic [7:0] readAddr,
  output logic [6:0] segOut16,
  output logic [6:0] segOut1,
  output logic [6:0] segPc16,
  output logic [6:0] segPc1,
  output logic [6:0] segOpcode,
  output logic       negLED
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [7:0]       pc;
  logic [7:0]       regs [4];
  logic [7:0]       out_r;
  logic [7:0]       dmem [16];
  logic [CNT_W-1:0] div_cnt;
  logic             en;

  logic [1:0]        op, rs, rt, rd;
  logic [7:0]        rs_val, rt_val, add_res, pc_next, out_mag;
  logic signed [3:0] imm_s;
  logic signed [7:0] off_s;
  logic [3:0]        maddr;

  assign op = inst[7:6];
  assign rs = inst[5:4];
  assign rt = inst[3:2];
  assign rd = inst[1:0];

  // Sign-extending imm2 only to 4 bits is enough: the memory address keeps 4 bits.
  assign imm_s   = {{2{inst[1]}}, inst[1:0]};
  assign off_s   = {{2{inst[5]}}, inst[5:0]};
  assign rs_val  = regs[rs];
  assign rt_val  = regs[rt];
  assign add_res = rs_val + rt_val;
  assign maddr   = rs_val[3:0] + $unsigned(imm_s);
  assign pc_next = (op == OP_JMP) ? (pc + 8'd1 + $unsigned(off_s)) : (pc + 8'd1);
  assign en      = (div_cnt == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge CLK_osc) begin
    if (RST) begin
      pc      <= '0;
      out_r   <= '0;
      div_cnt <= '0;
      for (int i = 0; i < 4; i++)  regs[i] <= '0;
      for (int i = 0; i < 16; i++) dmem[i] <= 8'(i);
    end else if (!HALT) begin
      div_cnt <= en ? '0 : div_cnt + CNT_W'(1);
      if (en) begin
        pc <= pc_next;
        case (op)
          OP_ADD: begin
            regs[rd] <= add_res;
            out_r    <= add_res;
          end
          OP_LOAD: begin
            regs[rt] <= dmem[maddr];
            out_r    <= dmem[maddr];
          end
          OP_STORE: begin
            dmem[maddr] <= rt_val;
            out_r       <= rt_val;
          end
          default: ;
        endcase
      end
    end
  end

  // 0x80 has no positive counterpart; negating it yields 0x80, shown as "80".
  assign out_mag  = out_r[7] ? (~out_r + 8'd1) : out_r;
  assign negLED   = out_r[7];
  assign readAddr = pc;

  seg7_hex u_seg_out16 (.hex(out_mag[7:4]),   .seg(segOut16));
  seg7_hex u_seg_out1  (.hex(out_mag[3:0]),   .seg(segOut1));
  seg7_hex u_seg_pc16  (.hex(pc[7:4]),        .seg(segPc16));
  seg7_hex u_seg_pc1   (.hex(pc[3:0]),        .seg(segPc1));
  seg7_hex u_seg_op    (.hex({2'b00, op}),    .seg(segOpcode));

endmodule

// File: tb/tb_proc_core.sv
// Directed bench for proc_core with a behavioural instruction ROM.
module tb_proc_core;

  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010,
                         S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100,
                         S8 = 7'b0000000, SA = 7'b0001000, SF = 7'b0111000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       halt = 1'b0;
  logic [7:0] inst;
  logic [7:0] read_addr;
  logic [6:0] seg_out16, seg_out1, seg_pc16, seg_pc1, seg_opcode;
  logic       neg_led;
  logic [7:0] rom [256];

  int n_cmp = 0;
  int n_fail = 0;

  assign inst = rom[read_addr];

  always #5 clk = ~clk;

  proc_core #(.CLK_DIV(1)) dut (
    .CLK_osc(clk), .RST(rst), .HALT(halt), .inst(inst), .readAddr(read_addr),
    .segOut16(seg_out16), .segOut1(seg_out1), .segPc16(seg_pc16),
    .segPc1(seg_pc1), .segOpcode(seg_opcode), .negLED(neg_led)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_rom();
    rom[0] = 8'h45;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if ({read_addr, neg_led, seg_out1, seg_pc1, seg_opcode} !== {8'd0, 1'b0, S0, S0, S1}) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got pc=%h neg=%b out1=%b pc1=%b op=%b, expected pc=00 neg=0 out1=%b pc1=%b op=%b",
                 c, read_addr, neg_led, seg_out1, seg_pc1, seg_opcode, S0, S0, S1);
      end
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({read_addr, seg_out1, seg_pc1} !== {8'd1, S1, S1}) begin
      n_fail++;
      $display("FAIL reset_release: got pc=%h out1=%b pc1=%b, expected pc=01 out1=%b pc1=%b",
               read_addr, seg_out1, seg_pc1, S1, S1);
    end
  endtask

  task automatic test_load_add();
    clear_rom();
    rom[0] = 8'h45;  // LOAD R1,[R0+1]
    rom[1] = 8'h59;  // LOAD R2,[R1+1]
    rom[2] = 8'h1B;  // ADD  R3=R1+R2
    do_reset();
    tick();
    tick();
    n_cmp++;
    if ({read_addr, seg_out1} !== {8'd2, S2}) begin
      n_fail++;
      $display("FAIL load_r2: got pc=%h out1=%b, expected pc=02 out1=%b", read_addr, seg_out1, S2);
    end
    tick();
    n_cmp++;
    if ({read_addr, neg_led, seg_out16, seg_out1, seg_pc1} !== {8'd3, 1'b0, S0, S3, S3}) begin
      n_fail++;
      $display("FAIL load_add: got pc=%h neg=%b out16=%b out1=%b pc1=%b, expected pc=03 neg=0 out16=%b out1=%b pc1=%b",
               read_addr, neg_led, seg_out16, seg_out1, seg_pc1, S0, S3, S3);
    end
  endtask

  task automatic test_store_load();
    clear_rom();
    rom[0] = 8'h45;  // LOAD  R1,[R0+1]  -> R1 = 1
    rom[1] = 8'h95;  // STORE [R1+1]=R1  -> DMEM[2] = 1
    rom[2] = 8'h5D;  // LOAD  R3,[R1+1]  -> R3 = 1
    rom[3] = 8'h3C;  // ADD   R0=R3+R3   -> 2
    do_reset();
    tick();
    tick();
    n_cmp++;
    if ({read_addr, seg_out1} !== {8'd2, S1}) begin
      n_fail++;
      $display("FAIL store_out: got pc=%h out1=%b, expected pc=02 out1=%b", read_addr, seg_out1, S1);
    end
    tick();
    n_cmp++;
    if (seg_out1 !== S1) begin
      n_fail++;
      $display("FAIL load_back: got out1=%b, expected %b", seg_out1, S1);
    end
    tick();
    n_cmp++;
    if ({read_addr, seg_out1} !== {8'd4, S2}) begin
      n_fail++;
      $display("FAIL r3_use: got pc=%h out1=%b, expected pc=04 out1=%b", read_addr, seg_out1, S2);
    end
    // A mid-program reset must restore DMEM[2] = 2.
    rom[1] = 8'h5D;
    do_reset();
    tick();
    tick();
    n_cmp++;
    if ({read_addr, seg_out1} !== {8'd2, S2}) begin
      n_fail++;
      $display("FAIL dmem_reset: got pc=%h out1=%b, expected pc=02 out1=%b", read_addr, seg_out1, S2);
    end
  endtask

  task automatic test_negative();
    clear_rom();
    rom[0] = 8'h47;  // LOAD R1,[R0-1] -> 15
    for (int i = 1; i <= 4; i++) rom[i] = 8'h15;  // R1 doubles to 240
    rom[5] = 8'h4B;  // LOAD R2,[R0-1] -> 15
    rom[6] = 8'h19;  // ADD  R1=R1+R2 -> 0xFF
    rom[7] = 8'h84;  // STORE [R0+0]=R1
    rom[8] = 8'h48;  // LOAD R2,[R0+0] -> 0xFF
    rom[9] = 8'h1B;  // ADD  R3=R1+R2 -> 0xFE
    do_reset();
    for (int c = 0; c < 7; c++) tick();
    n_cmp++;
    if ({neg_led, seg_out16, seg_out1} !== {1'b1, S0, S1}) begin
      n_fail++;
      $display("FAIL minus_one: got neg=%b out16=%b out1=%b, expected neg=1 out16=%b out1=%b",
               neg_led, seg_out16, seg_out1, S0, S1);
    end
    tick();
    tick();
    tick();
    n_cmp++;
    if ({read_addr, neg_led, seg_out16, seg_out1, seg_pc16, seg_pc1} !== {8'd10, 1'b1, S0, S2, S0, SA}) begin
      n_fail++;
      $display("FAIL minus_two: got pc=%h neg=%b out16=%b out1=%b pc16=%b pc1=%b, expected pc=0a neg=1 out16=%b out1=%b pc16=%b pc1=%b",
               read_addr, neg_led, seg_out16, seg_out1, seg_pc16, seg_pc1, S0, S2, S0, SA);
    end
  endtask

  task automatic test_min_neg();
    clear_rom();
    rom[0] = 8'h45;  // R1 = 1
    for (int i = 1; i <= 7; i++) rom[i] = 8'h15;  // R1 doubles to 0x80
    do_reset();
    for (int c = 0; c < 7; c++) tick();
    n_cmp++;
    if ({neg_led, seg_out16, seg_out1} !== {1'b0, S4, S0}) begin
      n_fail++;
      $display("FAIL pos_40: got neg=%b out16=%b out1=%b, expected neg=0 out16=%b out1=%b",
               neg_led, seg_out16, seg_out1, S4, S0);
    end
    tick();
    n_cmp++;
    if ({neg_led, seg_out16, seg_out1} !== {1'b1, S8, S0}) begin
      n_fail++;
      $display("FAIL neg_80: got neg=%b out16=%b out1=%b, expected neg=1 out16=%b out1=%b",
               neg_led, seg_out16, seg_out1, S8, S0);
    end
  endtask

  task automatic test_jump();
    clear_rom();
    rom[0] = 8'hC4;  // JMP +4 -> 5
    rom[5] = 8'hFF;  // JMP -1 -> stays at 5
    do_reset();
    tick();
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if ({read_addr, seg_pc1, seg_opcode, neg_led, seg_out1} !== {8'd5, S5, S3, 1'b0, S0}) begin
        n_fail++;
        $display("FAIL jmp_self[%0d]: got pc=%h pc1=%b op=%b neg=%b out1=%b, expected pc=05 pc1=%b op=%b neg=0 out1=%b",
                 c, read_addr, seg_pc1, seg_opcode, neg_led, seg_out1, S5, S3, S0);
      end
    end
    clear_rom();
    rom[0] = 8'hC2;
    do_reset();
    tick();
    n_cmp++;
    if (read_addr !== 8'd3) begin
      n_fail++;
      $display("FAIL jmp_fwd: got pc=%h, expected 03", read_addr);
    end
    clear_rom();
    rom[0]   = 8'hFE;  // JMP -2 -> 255
    rom[255] = 8'hC0;  // JMP +0 -> wraps to 0
    do_reset();
    tick();
    n_cmp++;
    if ({read_addr, seg_pc16, seg_pc1} !== {8'hFF, SF, SF}) begin
      n_fail++;
      $display("FAIL jmp_back: got pc=%h pc16=%b pc1=%b, expected pc=ff pc16=%b pc1=%b",
               read_addr, seg_pc16, seg_pc1, SF, SF);
    end
    tick();
    n_cmp++;
    if (read_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL jmp_wrap: got pc=%h, expected 00", read_addr);
    end
  endtask

  task automatic test_halt();
    clear_rom();
    rom[0] = 8'h45;
    for (int i = 1; i <= 4; i++) rom[i] = 8'h15;
    do_reset();
    for (int c = 0; c < 4; c++) tick();
    halt = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if ({read_addr, seg_out16, seg_out1} !== {8'd4, S0, S8}) begin
        n_fail++;
        $display("FAIL halt_hold[%0d]: got pc=%h out16=%b out1=%b, expected pc=04 out16=%b out1=%b",
                 c, read_addr, seg_out16, seg_out1, S0, S8);
      end
    end
    halt = 1'b0;
    tick();
    n_cmp++;
    if ({read_addr, seg_out16, seg_out1} !== {8'd5, S1, S0}) begin
      n_fail++;
      $display("FAIL halt_resume: got pc=%h out16=%b out1=%b, expected pc=05 out16=%b out1=%b",
               read_addr, seg_out16, seg_out1, S1, S0);
    end
    halt = 1'b1;
    rst  = 1'b1;
    tick();
    n_cmp++;
    if ({read_addr, seg_out16, seg_out1} !== {8'd0, S0, S0}) begin
      n_fail++;
      $display("FAIL rst_over_halt: got pc=%h out16=%b out1=%b, expected pc=00 out16=%b out1=%b",
               read_addr, seg_out16, seg_out1, S0, S0);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (read_addr !== 8'd0) begin
      n_fail++;
      $display("FAIL halt_after_rst: got pc=%h, expected 00", read_addr);
    end
    halt = 1'b0;
    tick();
    n_cmp++;
    if (read_addr !== 8'd1) begin
      n_fail++;
      $display("FAIL halt_release: got pc=%h, expected 01", read_addr);
    end
  endtask

  initial begin
    test_reset();
    test_load_add();
    test_store_load();
    test_negative();
    test_min_neg();
    test_jump();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
